mpu_seq_engine: RTL and testbench



---
 rtl/mpu_seq_engine.sv | 219 +++++++++++++++++++++
 tb/tb_mpu_seq_engine.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_seq_engine.sv
// mpu_seq_engine
//   Multi-cycle matrix operation engine placed between the MPU instruction
//   decoder and the matrix register file. On an accepted start it latches two
//   DIM x DIM signed operand matrices, an opcode, an active size n and a
//   scalar. It then builds the result one row per cycle (elementwise ops) or
//   one element per cycle (matrix multiply) and pulses done when finished.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high; clears every register
//   start      : request, taken only while busy=0
//   operation  : 0 add, 1 sub, 2 scalar mul, 3 opposite, 4 transpose,
//                6 matrix mul; 5 and 7 are reserved
//   size       : active dimension n, legal 1..DIM
//   factor     : signed scalar for scalar mul
//   matrix_a/b : operands, element (i,j) at [(i*DIM+j)*WIDTH +: WIDTH]
//   busy       : operation in progress
//   done       : one-cycle completion pulse
//   result     : signed result, same layout, held until the next accept
//   overflow   : some element of the current result was truncated
//   error      : last accepted request had a bad size or reserved opcode
//   dbg_state  : current FSM state (IDLE=0, RUN=1, FINISH=2)
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (that includes the done cycle). busy rises on that same edge and all
// request inputs are sampled only then; start while busy=1 is dropped.

module mpu_seq_engine #(
   parameter int DIM   = 5,
   parameter int WIDTH = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   input  logic [2:0]                 operation,
   input  logic [7:0]                 size,
   input  logic [WIDTH-1:0]           factor,
   input  logic [DIM*DIM*WIDTH-1:0]   matrix_a,
   input  logic [DIM*DIM*WIDTH-1:0]   matrix_b,
   output logic                       busy,
   output logic                       done,
   output logic [DIM*DIM*WIDTH-1:0]   result,
   output logic                       overflow,
   output logic                       error,
   output logic [1:0]                 dbg_state
);

   localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   // Wide enough for a full DIM-term dot product of WIDTH-bit operands.
   localparam int ACC_W = 2 * WIDTH + IDX_W;
   localparam int MW    = DIM * DIM * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   state_e                   state_q;
   logic [2:0]               op_q;
   logic [7:0]               n_q;
   logic [WIDTH-1:0]         factor_q;
   logic [MW-1:0]            a_q;
   logic [MW-1:0]            b_q;
   logic [IDX_W-1:0]         row_q;
   logic [IDX_W-1:0]         col_q;
   logic [MW-1:0]            result_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     overflow_q;
   logic                     error_q;

   logic [DIM*WIDTH-1:0]     row_d;
   logic                     row_ovf_d;
   logic signed [ACC_W-1:0]  el_v;
   logic signed [ACC_W-1:0]  dot_d;
   logic                     dot_ovf_d;
   logic                     req_bad;
   logic                     last_row;
   logic                     last_col;

   // Sign-extended element (i,j) of a packed matrix.
   function automatic logic signed [ACC_W-1:0] get_el(input logic [MW-1:0] m,
                                                      input int i, input int j);
      logic [WIDTH-1:0] e;
      e = m[(i * DIM + j) * WIDTH +: WIDTH];
      return {{(ACC_W - WIDTH){e[WIDTH-1]}}, e};
   endfunction

   // Value fits in WIDTH signed bits only if every bit from the WIDTH-1
   // sign position upward is identical.
   function automatic logic does_ovf(input logic signed [ACC_W-1:0] v);
      return !((&v[ACC_W-1:WIDTH-1]) || (~|v[ACC_W-1:WIDTH-1]));
   endfunction

   assign req_bad  = (size == 8'd0) || (size > 8'(DIM)) ||
                     (operation == 3'd5) || (operation == 3'd7);
   assign last_row = (8'(row_q) == n_q - 8'd1);
   assign last_col = (8'(col_q) == n_q - 8'd1);

   // One full row of an elementwise op; columns >= n stay zero.
   always_comb begin
      row_d     = '0;
      row_ovf_d = 1'b0;
      el_v      = '0;
      for (int j = 0; j < DIM; j++) begin
         case (op_q)
            3'd0:    el_v = get_el(a_q, int'(row_q), j) + get_el(b_q, int'(row_q), j);
            3'd1:    el_v = get_el(a_q, int'(row_q), j) - get_el(b_q, int'(row_q), j);
            3'd2:    el_v = get_el(a_q, int'(row_q), j) *
                            {{(ACC_W - WIDTH){factor_q[WIDTH-1]}}, factor_q};
            3'd3:    el_v = -get_el(a_q, int'(row_q), j);
            3'd4:    el_v = get_el(a_q, j, int'(row_q));
            default: el_v = '0;
         endcase
         if (j < int'(n_q)) begin
            row_d[j*WIDTH +: WIDTH] = el_v[WIDTH-1:0];
            row_ovf_d               = row_ovf_d | does_ovf(el_v);
         end
      end
   end

   // Dot product for matrix element (row_q, col_q) over k < n.
   always_comb begin
      dot_d = '0;
      for (int k = 0; k < DIM; k++) begin
         if (k < int'(n_q)) begin
            dot_d = dot_d + get_el(a_q, int'(row_q), k) * get_el(b_q, k, int'(col_q));
         end
      end
      dot_ovf_d = does_ovf(dot_d);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         n_q        <= '0;
         factor_q   <= '0;
         a_q        <= '0;
         b_q        <= '0;
         row_q      <= '0;
         col_q      <= '0;
         result_q   <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_FINISH: begin
               // FINISH is the done cycle; it accepts a new start like IDLE.
               done_q  <= 1'b0;
               state_q <= S_IDLE;
               if (start) begin
                  op_q       <= operation;
                  n_q        <= size;
                  factor_q   <= factor;
                  a_q        <= matrix_a;
                  b_q        <= matrix_b;
                  row_q      <= '0;
                  col_q      <= '0;
                  result_q   <= '0;
                  overflow_q <= 1'b0;
                  error_q    <= req_bad;
                  busy_q     <= 1'b1;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               if (error_q) begin
                  // Bad request: nothing computed, finish after one cycle.
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_FINISH;
               end else if (op_q == 3'd6) begin
                  result_q[(int'(row_q) * DIM + int'(col_q)) * WIDTH +: WIDTH] <= dot_d[WIDTH-1:0];
                  overflow_q <= overflow_q | dot_ovf_d;
                  if (last_col) begin
                     col_q <= '0;
                     if (last_row) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                     end else begin
                        row_q <= row_q + IDX_W'(1);
                     end
                  end else begin
                     col_q <= col_q + IDX_W'(1);
                  end
               end else begin
                  result_q[int'(row_q) * DIM * WIDTH +: DIM * WIDTH] <= row_d;
                  overflow_q <= overflow_q | row_ovf_d;
                  if (last_row) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_FINISH;
                  end else begin
                     row_q <= row_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign error     = error_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mpu_seq_engine.sv
// Directed bench for mpu_seq_engine: hand-computed expected matrices,
// latencies and flags for each operation, masking, errors and reset abort.

module tb_mpu_seq_engine;

   localparam int DIM = 5;
   localparam int W   = 8;
   localparam int MW  = DIM * DIM * W;

   logic            clock = 1'b0;
   logic            reset;
   logic            start;
   logic [2:0]      operation;
   logic [7:0]      size;
   logic [W-1:0]    factor;
   logic [MW-1:0]   matrix_a;
   logic [MW-1:0]   matrix_b;
   logic            busy;
   logic            done;
   logic [MW-1:0]   result;
   logic            overflow;
   logic            error;
   logic [1:0]      dbg_state;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [MW-1:0]   exp_m;

   mpu_seq_engine #(.DIM(DIM), .WIDTH(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .operation (operation),
      .size      (size),
      .factor    (factor),
      .matrix_a  (matrix_a),
      .matrix_b  (matrix_b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .overflow  (overflow),
      .error     (error),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int i, input int j);
      return m[(i * DIM + j) * W +: W];
   endfunction

   // ---------------- drivers ----------------
   // Called #1 after an edge: present a request, let it be accepted, then
   // scramble all request inputs to prove they were latched.
   task automatic launch(input logic [2:0] op, input logic [7:0] n,
                         input logic [W-1:0] f, input string tag);
      operation = op;
      size      = n;
      factor    = f;
      start     = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, MW'(busy), MW'(1));
      operation = 3'($urandom_range(0, 7));
      size      = 8'($urandom_range(0, 255));
      factor    = W'($urandom);
      for (int i = 0; i < DIM * DIM; i++) begin
         matrix_a[i*W +: W] = W'($urandom);
         matrix_b[i*W +: W] = W'($urandom);
      end
   endtask

   // Count edges after acceptance until done; optionally pulse start mid-run.
   task automatic wait_done(input string tag, input int exp_lat, input int pulse_at);
      int c;
      c = 0;
      while (c < 100) begin
         c++;
         @(posedge clock);
         #1;
         if (done) break;
         start = (c == pulse_at);
      end
      start = 1'b0;
      check({tag, "_lat"}, MW'(c), MW'(exp_lat));
      check({tag, "_busy_at_done"}, MW'(busy), MW'(0));
   endtask

   task automatic load_rows_sum;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            matrix_a[(i*DIM+j)*W +: W] = W'(i + j);
            matrix_b[(i*DIM+j)*W +: W] = W'(1);
         end
   endtask

   task automatic load_ident_seq;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++) begin
            matrix_a[(i*DIM+j)*W +: W] = (i == j) ? W'(1) : W'(0);
            matrix_b[(i*DIM+j)*W +: W] = W'(i * 5 + j);
         end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset     = 1'b1;
      start     = 1'b1;
      operation = 3'd0;
      size      = 8'd2;
      factor    = '0;
      matrix_a  = '1;
      matrix_b  = '1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_busy", MW'(busy), MW'(0));
      check("rst_done", MW'(done), MW'(0));
      check("rst_result", result, '0);
      check("rst_ovf", MW'(overflow), MW'(0));
      check("rst_err", MW'(error), MW'(0));
      check("rst_state", MW'(dbg_state), MW'(0));
      reset = 1'b0;
      start = 1'b0;
      @(posedge clock);
      #1;
      check("idle_busy", MW'(busy), MW'(0));

      // add n=3: a(i,j)=i+j, b=1 -> i+j+1 inside 3x3, zero elsewhere
      load_rows_sum();
      exp_m = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            exp_m[(i*DIM+j)*W +: W] = W'(i + j + 1);
      launch(3'd0, 8'd3, '0, "add");
      wait_done("add", 3, 0);
      check("add_result", result, exp_m);
      check("add_ovf", MW'(overflow), MW'(0));
      check("add_err", MW'(error), MW'(0));
      @(posedge clock);
      #1;
      check("add_done_drop", MW'(done), MW'(0));
      check("add_hold", result, exp_m);

      // scalar mul n=2, factor 2: 100->0xC8 (ovf), -5->0xF6, 3->6, (3,3) masked
      matrix_a = '0;
      matrix_a[(0*DIM+0)*W +: W] = 8'd100;
      matrix_a[(1*DIM+0)*W +: W] = 8'hFB;
      matrix_a[(1*DIM+1)*W +: W] = 8'd3;
      matrix_a[(3*DIM+3)*W +: W] = 8'd50;
      exp_m = '0;
      exp_m[(0*DIM+0)*W +: W] = 8'hC8;
      exp_m[(1*DIM+0)*W +: W] = 8'hF6;
      exp_m[(1*DIM+1)*W +: W] = 8'h06;
      launch(3'd2, 8'd2, 8'd2, "smul");
      wait_done("smul", 2, 0);
      check("smul_result", result, exp_m);
      check("smul_ovf", MW'(overflow), MW'(1));

      // opposite n=1: -(-128) wraps to -128 with overflow
      matrix_a = '0;
      matrix_a[(0*DIM+0)*W +: W] = 8'h80;
      matrix_a[(0*DIM+1)*W +: W] = 8'd5;
      exp_m = '0;
      exp_m[(0*DIM+0)*W +: W] = 8'h80;
      launch(3'd3, 8'd1, '0, "opp");
      wait_done("opp", 1, 0);
      check("opp_result", result, exp_m);
      check("opp_ovf", MW'(overflow), MW'(1));

      // transpose n=5: a(i,j)=i*5+j except a(1,3)=7
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            matrix_a[(i*DIM+j)*W +: W] = W'(i * 5 + j);
      matrix_a[(1*DIM+3)*W +: W] = 8'd7;
      exp_m = '0;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            exp_m[(j*DIM+i)*W +: W] = W'(i * 5 + j);
      exp_m[(3*DIM+1)*W +: W] = 8'd7;
      launch(3'd4, 8'd5, '0, "tr");
      wait_done("tr", 5, 0);
      check("tr_result", result, exp_m);
      check("tr_31", MW'(el(result, 3, 1)), MW'(7));
      check("tr_ovf", MW'(overflow), MW'(0));

      // matrix mul n=5: identity x B = B, start pulsed mid-run is ignored
      load_ident_seq();
      exp_m = '0;
      for (int i = 0; i < DIM; i++)
         for (int j = 0; j < DIM; j++)
            exp_m[(i*DIM+j)*W +: W] = W'(i * 5 + j);
      launch(3'd6, 8'd5, '0, "mm5");
      wait_done("mm5", 25, 10);
      check("mm5_result", result, exp_m);
      check("mm5_ovf", MW'(overflow), MW'(0));
      @(posedge clock);
      #1;
      check("mm5_no_restart", MW'(busy), MW'(0));

      // matrix mul n=2: [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]]
      matrix_a = '0;
      matrix_b = '0;
      matrix_a[(0*DIM+0)*W +: W] = 8'd1;
      matrix_a[(0*DIM+1)*W +: W] = 8'd2;
      matrix_a[(1*DIM+0)*W +: W] = 8'd3;
      matrix_a[(1*DIM+1)*W +: W] = 8'd4;
      matrix_a[(2*DIM+2)*W +: W] = 8'd9;
      matrix_b[(0*DIM+0)*W +: W] = 8'd5;
      matrix_b[(0*DIM+1)*W +: W] = 8'd6;
      matrix_b[(1*DIM+0)*W +: W] = 8'd7;
      matrix_b[(1*DIM+1)*W +: W] = 8'd8;
      matrix_b[(2*DIM+2)*W +: W] = 8'd9;
      exp_m = '0;
      exp_m[(0*DIM+0)*W +: W] = 8'd19;
      exp_m[(0*DIM+1)*W +: W] = 8'd22;
      exp_m[(1*DIM+0)*W +: W] = 8'd43;
      exp_m[(1*DIM+1)*W +: W] = 8'd50;
      launch(3'd6, 8'd2, '0, "mm2");
      wait_done("mm2", 4, 0);
      check("mm2_result", result, exp_m);
      check("mm2_ovf", MW'(overflow), MW'(0));

      // back-to-back from the done cycle: sub n=1, 5-9 = -4
      matrix_a = '0;
      matrix_b = '0;
      matrix_a[0 +: W] = 8'd5;
      matrix_b[0 +: W] = 8'd9;
      exp_m = '0;
      exp_m[0 +: W] = 8'hFC;
      launch(3'd1, 8'd1, '0, "b2b");
      wait_done("b2b", 1, 0);
      check("b2b_result", result, exp_m);
      check("b2b_ovf", MW'(overflow), MW'(0));

      // matrix mul overflow n=2: 100*100*2 = 20000 = 0x4E20 -> 0x20
      matrix_a = '0;
      matrix_b = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) begin
            matrix_a[(i*DIM+j)*W +: W] = 8'd100;
            matrix_b[(i*DIM+j)*W +: W] = 8'd100;
         end
      exp_m = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            exp_m[(i*DIM+j)*W +: W] = 8'h20;
      launch(3'd6, 8'd2, '0, "mmov");
      wait_done("mmov", 4, 0);
      check("mmov_result", result, exp_m);
      check("mmov_ovf", MW'(overflow), MW'(1));

      // errors: size 6, size 0, opcode 5
      load_rows_sum();
      launch(3'd0, 8'd6, '0, "err6");
      wait_done("err6", 1, 0);
      check("err6_err", MW'(error), MW'(1));
      check("err6_result", result, '0);
      check("err6_ovf", MW'(overflow), MW'(0));
      load_rows_sum();
      launch(3'd0, 8'd0, '0, "err0");
      wait_done("err0", 1, 0);
      check("err0_err", MW'(error), MW'(1));
      load_rows_sum();
      launch(3'd5, 8'd2, '0, "op5");
      wait_done("op5", 1, 0);
      check("op5_err", MW'(error), MW'(1));
      check("op5_result", result, '0);

      // reset in the middle of a 25-cycle multiply
      load_ident_seq();
      launch(3'd6, 8'd5, '0, "abort");
      repeat (9) @(posedge clock);
      #1;
      check("abort_busy_mid", MW'(busy), MW'(1));
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("abort_busy", MW'(busy), MW'(0));
      check("abort_done", MW'(done), MW'(0));
      check("abort_result", result, '0);
      check("abort_ovf", MW'(overflow), MW'(0));
      check("abort_err", MW'(error), MW'(0));
      check("abort_state", MW'(dbg_state), MW'(0));

      // normal add n=2 after the abort
      load_rows_sum();
      exp_m = '0;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            exp_m[(i*DIM+j)*W +: W] = W'(i + j + 1);
      launch(3'd0, 8'd2, '0, "post");
      wait_done("post", 2, 0);
      check("post_result", result, exp_m);
      check("post_err", MW'(error), MW'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
